hwpf_arbiter: RTL and testbench
===============================

HWPF_ARBITER -- requirements
Module: hwpf_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 4; number of prefetch engines sharing the dcache request port.
REQ-002: Parameter BUDGET, default 4; maximum grants per throttle window, range 1..WINDOW.
REQ-003: Parameter WINDOW, default 16; throttle window length in cycles, range 2..256.
REQ-004: Parameter SID, default 0; source ID driven on every emitted request.
REQ-005: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-006: rst_ni  input  1  reset, synchronous and active-low.
REQ-007: flush_i  input  1  drop the buffered request and restart the throttle window.
REQ-008: lock_i  input  1  suspend all grants and emission.
REQ-009: req_valid_i  input  NUM_REQ  per-engine request valid.
REQ-010: req_addr_i  input  NUM_REQ x addr_t  per-engine prefetch line address.
REQ-011: req_ready_o  output  NUM_REQ  per-engine grant, one-hot or zero.
REQ-012: arbiter_req_valid_o  output  1  buffered request valid toward the dcache.
REQ-013: arbiter_req_ready_i  input  1  dcache accepts the request.
REQ-014: arbiter_req_o  output  hpdcache_req_t  emitted request.

Function
REQ-015: One-entry output buffer, states EMPTY and FULL; arbiter_req_valid_o SHALL equal (FULL && !lock_i).
REQ-016: Handshake completes when arbiter_req_valid_o && arbiter_req_ready_i; FULL->EMPTY unless a grant in the same cycle refills it (FULL stays FULL, new contents).
REQ-017: Grant allowed when !lock_i && !flush_i && budget not exhausted && (EMPTY || handshake this cycle) && any req_valid_i.
REQ-018: Grant SHALL be combinational in the cycle it is allowed; winner's addr and index load into the buffer at the next edge (1-cycle latency, req to valid).
REQ-019: Round-robin: search starts at rr_ptr, ascending mod NUM_REQ; after a grant to i, rr_ptr = (i+1) mod NUM_REQ; no grant leaves rr_ptr unchanged.
REQ-020: req_ready_o SHALL be all zero when no grant is allowed, including under lock_i and flush_i.
REQ-021: Window counter counts 0..WINDOW-1 every cycle, wraps to 0; issue counter increments per grant and clears on wrap.
REQ-022: Grant in the wrap cycle SHALL set the issue counter to 1, not BUDGET+1 nor 0.
REQ-023: Budget exhausted when issue counter == BUDGET; grants blocked until the next wrap.
REQ-024: lock_i: buffer contents, rr_ptr and counters held (window counter keeps running); emission resumes unchanged after release.
REQ-025: flush_i: buffer -> EMPTY, window and issue counters -> 0, rr_ptr held; a handshake in the same cycle still counts as accepted downstream.
REQ-026: arbiter_req_o.addr = buffered addr; tid = buffered requester index, zero-extended; sid = SID; uncacheable = 0; need_rsp = 0; op = prefetch; remaining fields zero.
REQ-027: Buffered request SHALL stay stable while arbiter_req_valid_o && !arbiter_req_ready_i.

Reset
REQ-028: With rst_ni low at an edge: buffer EMPTY, rr_ptr = 0, window and issue counters = 0, buffered addr/tid = 0.
REQ-029: During and after reset, until the first grant: arbiter_req_valid_o = 0, req_ready_o = 0.
REQ-030: Reset asserted mid-handshake or mid-window SHALL discard the buffered request; no emission in the cycle after release.

Verification (NUM_REQ=4, BUDGET=2, WINDOW=8)
REQ-031: Engines 0..3 all valid, ready_i=1, budget large -> grants 0,1,2,3,0 on successive cycles; tid follows 1 cycle later.
REQ-032: Engine 2 valid addr 0x1000, ready_i=0 for 5 cycles -> valid=1, addr 0x1000 held for 5 cycles; no further grant; accepted on the ready cycle.
REQ-033: Continuous requests from reset -> exactly 2 grants in cycles 0..7; next grant at cycle 8 (wrap), issue counter = 1.
REQ-034: Buffer FULL, lock_i=1 for 3 cycles, ready_i=1 -> valid=0, req_ready_o=0; on release same addr emitted.
REQ-035: Buffer FULL with addr 0x2040, flush_i pulse -> buffer EMPTY next cycle, no grant in the flush cycle, 2 new grants allowed immediately after.
REQ-036: rst_ni low for 1 cycle while FULL -> valid=0 after the edge; first post-reset grant goes to engine 0.

Source files
------------

// File: rtl/hwpf_arbiter.sv
// hwpf_arbiter: round-robin arbiter for NUM_REQ hardware prefetch engines
// that share one dcache request port. The winner is granted combinationally
// and parked in a one-entry output buffer. A window/budget throttle caps
// the number of grants per WINDOW cycles at BUDGET.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                drop buffered request, restart throttle window
//   lock_i                 suspend grants and emission (state held)
//   req_valid_i/addr_i     per-engine prefetch requests
//   req_ready_o            per-engine grant, one-hot or zero
//   arbiter_req_valid_o    buffered request valid toward the dcache
//   arbiter_req_ready_i    dcache accepts the request
//   arbiter_req_o          emitted dcache request

typedef logic [39:0] addr_t;

typedef struct packed {
    addr_t      addr;
    logic [3:0] op;
    logic [7:0] tid;
    logic [7:0] sid;
    logic [2:0] size;
    logic [7:0] be;
    logic       uncacheable;
    logic       need_rsp;
} hpdcache_req_t;

localparam logic [3:0] HPDCACHE_REQ_OP_PREFETCH = 4'd3;

module hwpf_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BUDGET  = 4,
    parameter int WINDOW  = 16,
    parameter int SID     = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       lock_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  addr_t [NUM_REQ-1:0]        req_addr_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       arbiter_req_valid_o,
    input  logic                       arbiter_req_ready_i,
    output hpdcache_req_t              arbiter_req_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WIN_W = $clog2(WINDOW);
    localparam int ISS_W = $clog2(BUDGET + 1);

    // Output buffer states
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    addr_t            addr_q, addr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [ISS_W-1:0] iss_q, iss_d;

    logic             handshake;
    logic             wrap;
    logic             exhausted;
    logic             grant;
    logic             found;
    logic [IDX_W-1:0] win_idx;

    assign arbiter_req_valid_o = (state_q == FULL) && !lock_i;
    assign handshake = arbiter_req_valid_o && arbiter_req_ready_i;
    assign wrap      = (win_q == WIN_W'(WINDOW - 1));
    assign exhausted = (iss_q == ISS_W'(BUDGET));

    // Rotating priority search starting at rr_q.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid_i[(int'(rr_q) + k) % NUM_REQ]) begin
                found   = 1'b1;
                win_idx = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    // rst_ni gates the grant so no engine sees ready while reset is held.
    assign grant = rst_ni && !lock_i && !flush_i && !exhausted &&
                   ((state_q == EMPTY) || handshake) && found;

    always_comb begin
        req_ready_o = '0;
        if (grant) req_ready_o[win_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        win_d   = wrap ? '0 : win_q + 1'b1;
        iss_d   = iss_q;

        // Clearing on wrap and counting the grant are combined so a grant
        // landing on the wrap cycle opens the new window with one issue.
        if (wrap)       iss_d = grant ? ISS_W'(1) : '0;
        else if (grant) iss_d = iss_q + 1'b1;

        if (grant) begin
            state_d = FULL;
            addr_d  = req_addr_i[win_idx];
            idx_d   = win_idx;
            rr_d    = IDX_W'((int'(win_idx) + 1) % NUM_REQ);
        end else if (handshake) begin
            state_d = EMPTY;
        end

        // A handshake coinciding with flush is still accepted downstream;
        // the buffer simply empties either way.
        if (flush_i) begin
            state_d = EMPTY;
            win_d   = '0;
            iss_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            addr_q  <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            win_q   <= '0;
            iss_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            iss_q   <= iss_d;
        end
    end

    always_comb begin
        arbiter_req_o             = '0;
        arbiter_req_o.addr        = addr_q;
        arbiter_req_o.op          = HPDCACHE_REQ_OP_PREFETCH;
        arbiter_req_o.tid         = 8'(idx_q);
        arbiter_req_o.sid         = 8'(SID);
        arbiter_req_o.uncacheable = 1'b0;
        arbiter_req_o.need_rsp    = 1'b0;
    end

endmodule

// File: tb/tb_hwpf_arbiter.sv
// Directed bench for hwpf_arbiter. u_dut uses NUM_REQ=4, BUDGET=2, WINDOW=8;
// u_big lifts the budget to 8 so a full round-robin sweep is visible.
module tb_hwpf_arbiter;

    localparam int D_SID = 5;
    localparam int B_SID = 3;

    logic             clk = 1'b0;
    logic             rst_n, flush, lock, arb_rdy;
    logic [3:0]       req_valid;
    logic [3:0][39:0] req_addr;
    logic [3:0]       d_rdy, b_rdy;
    logic             d_vld, b_vld;
    logic [72:0]      d_req, b_req;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hwpf_arbiter #(.NUM_REQ(4), .BUDGET(2), .WINDOW(8), .SID(D_SID)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(d_rdy),
        .arbiter_req_valid_o(d_vld), .arbiter_req_ready_i(arb_rdy),
        .arbiter_req_o(d_req));

    hwpf_arbiter #(.NUM_REQ(4), .BUDGET(8), .WINDOW(8), .SID(B_SID)) u_big (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(b_rdy),
        .arbiter_req_valid_o(b_vld), .arbiter_req_ready_i(arb_rdy),
        .arbiter_req_o(b_req));

    // Packed layout: addr[40] op[4] tid[8] sid[8] size[3] be[8] unc need_rsp
    function automatic logic [72:0] mk(input logic [39:0] a, input int t, input int s);
        return {a, 4'h3, 8'(t), 8'(s), 13'b0};
    endfunction

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    // Apply one reset edge; returns in cycle 0 of a fresh window.
    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; lock = 1'b0; arb_rdy = 1'b0; req_valid = '0;
        nxt();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; lock = 1'b0; arb_rdy = 1'b1; req_valid = 4'hF;
        req_addr = '0;
        nxt();
        #1;
        n_tests++; if (d_rdy !== 4'b0) begin n_fail++; $display("FAIL reset_rdy_during got %b exp 0000", d_rdy); end
        n_tests++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld_during got %b exp 0", d_vld); end
        n_tests++; if (d_req !== mk(40'h0, 0, D_SID)) begin n_fail++; $display("FAIL reset_req got %h exp %h", d_req, mk(40'h0, 0, D_SID)); end
        rst_n = 1'b1; req_valid = '0;
        #1;
        n_tests++; if (d_vld !== 1'b0 || d_rdy !== 4'b0) begin n_fail++; $display("FAIL reset_after got vld=%b rdy=%b exp 0/0000", d_vld, d_rdy); end
        nxt();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[i] = 40'h100 * (i + 1);
        req_valid = 4'hF; arb_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_tests++; if (b_rdy !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_grant k=%0d got %b exp %b", k, b_rdy, 4'(1 << (k % 4))); end
            if (k >= 1) begin
                n_tests++; if (b_vld !== 1'b1 || b_req !== mk(40'h100 * ((k - 1) % 4 + 1), (k - 1) % 4, B_SID)) begin
                    n_fail++; $display("FAIL rr_req k=%0d got vld=%b req=%h exp 1/%h", k, b_vld, b_req, mk(40'h100 * ((k - 1) % 4 + 1), (k - 1) % 4, B_SID)); end
            end
            nxt();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_addr[2] = 40'h1000; req_valid = 4'b0100; arb_rdy = 1'b0;
        #1;
        n_tests++; if (d_rdy !== 4'b0100) begin n_fail++; $display("FAIL hold_grant got %b exp 0100", d_rdy); end
        nxt();
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) begin arb_rdy = 1'b1; req_valid = '0; end
            #1;
            n_tests++; if (d_vld !== 1'b1 || d_req !== mk(40'h1000, 2, D_SID) || d_rdy !== 4'b0) begin
                n_fail++; $display("FAIL hold_stable k=%0d got vld=%b req=%h rdy=%b exp 1/%h/0000", k, d_vld, d_req, d_rdy, mk(40'h1000, 2, D_SID)); end
            nxt();
        end
        #1;
        n_tests++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL hold_accepted got vld=%b exp 0", d_vld); end
    endtask

    task automatic test_budget();
        logic [3:0] exp_rdy [11] = '{4'b0001, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b1000, 4'b0};
        do_reset();
        req_valid = 4'hF; arb_rdy = 1'b1;
        for (int k = 0; k < 11; k++) begin
            #1;
            n_tests++; if (d_rdy !== exp_rdy[k]) begin n_fail++; $display("FAIL budget_cycle k=%0d got %b exp %b", k, d_rdy, exp_rdy[k]); end
            if (k == 3) begin
                n_tests++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL budget_drain got vld=%b exp 0", d_vld); end
            end
            nxt();
        end
    endtask

    task automatic test_wrap_grant();
        logic [3:0] exp_rdy [10] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0001, 4'b0};
        do_reset();
        req_addr[0] = 40'h3000; arb_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 7) req_valid = 4'b0001;
            #1;
            n_tests++; if (d_rdy !== exp_rdy[k]) begin n_fail++; $display("FAIL wrap_cycle k=%0d got %b exp %b", k, d_rdy, exp_rdy[k]); end
            nxt();
        end
        req_valid = '0;
    endtask

    task automatic test_lock();
        do_reset();
        req_addr[0] = 40'hABC0; req_valid = 4'b0001; arb_rdy = 1'b0;
        #1;
        n_tests++; if (d_rdy !== 4'b0001) begin n_fail++; $display("FAIL lock_grant got %b exp 0001", d_rdy); end
        nxt();
        lock = 1'b1; arb_rdy = 1'b1; req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (d_vld !== 1'b0 || d_rdy !== 4'b0) begin n_fail++; $display("FAIL lock_held k=%0d got vld=%b rdy=%b exp 0/0000", k, d_vld, d_rdy); end
            nxt();
        end
        lock = 1'b0; req_valid = '0;
        #1;
        n_tests++; if (d_vld !== 1'b1 || d_req !== mk(40'hABC0, 0, D_SID)) begin n_fail++; $display("FAIL lock_release got vld=%b req=%h exp 1/%h", d_vld, d_req, mk(40'hABC0, 0, D_SID)); end
        nxt();
        #1;
        n_tests++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL lock_accepted got vld=%b exp 0", d_vld); end
    endtask

    task automatic test_flush();
        do_reset();
        req_addr[1] = 40'h2040; req_addr[2] = 40'h2080; req_addr[3] = 40'h20C0;
        req_valid = 4'b0010; arb_rdy = 1'b0;
        #1;
        n_tests++; if (d_rdy !== 4'b0010) begin n_fail++; $display("FAIL flush_fill got %b exp 0010", d_rdy); end
        nxt();
        flush = 1'b1; req_valid = 4'hF;
        #1;
        n_tests++; if (d_rdy !== 4'b0 || d_vld !== 1'b1 || d_req !== mk(40'h2040, 1, D_SID)) begin
            n_fail++; $display("FAIL flush_cycle got rdy=%b vld=%b req=%h exp 0000/1/%h", d_rdy, d_vld, d_req, mk(40'h2040, 1, D_SID)); end
        nxt();
        flush = 1'b0; arb_rdy = 1'b1;
        #1;
        n_tests++; if (d_vld !== 1'b0 || d_rdy !== 4'b0100) begin n_fail++; $display("FAIL flush_after got vld=%b rdy=%b exp 0/0100", d_vld, d_rdy); end
        nxt();
        #1;
        n_tests++; if (d_rdy !== 4'b1000 || d_req !== mk(40'h2080, 2, D_SID)) begin n_fail++; $display("FAIL flush_second got rdy=%b req=%h exp 1000/%h", d_rdy, d_req, mk(40'h2080, 2, D_SID)); end
        nxt();
        #1;
        n_tests++; if (d_rdy !== 4'b0 || d_vld !== 1'b1 || d_req !== mk(40'h20C0, 3, D_SID)) begin
            n_fail++; $display("FAIL flush_budget got rdy=%b vld=%b req=%h exp 0000/1/%h", d_rdy, d_vld, d_req, mk(40'h20C0, 3, D_SID)); end
        nxt();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0001; arb_rdy = 1'b0;
        nxt();
        rst_n = 1'b0; req_valid = 4'hF;
        #1;
        n_tests++; if (d_rdy !== 4'b0) begin n_fail++; $display("FAIL rstmid_rdy got %b exp 0000", d_rdy); end
        nxt();
        rst_n = 1'b1; arb_rdy = 1'b1;
        #1;
        n_tests++; if (d_vld !== 1'b0 || d_rdy !== 4'b0001) begin n_fail++; $display("FAIL rstmid_after got vld=%b rdy=%b exp 0/0001", d_vld, d_rdy); end
        nxt();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; lock = 1'b0; arb_rdy = 1'b0; req_valid = '0; req_addr = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_budget();
        test_wrap_grant();
        test_lock();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
